// File: rtl/alu_pkg.sv
// Shared opcode constants, pipeline latency and tag control record for the
// ALU issue stage.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LDI  = 4'b0010;
  localparam logic [3:0] OP_NOP  = 4'b0011;
  localparam logic [3:0] OP_LAND = 4'b1000;
  localparam logic [3:0] OP_LOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_ROR  = 4'b1110;
  localparam logic [3:0] OP_ROL  = 4'b1111;

  // Accept edge to write-back edge, in clock edges.
  localparam int LAT = 3;

  typedef struct packed {
    logic valid;
    logic wen;
    logic is_ldi;
  } tag_ctl_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_LAND, OP_LOR, OP_XOR,
      OP_NOT, OP_SHR, OP_SHL, OP_ROR, OP_ROL: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic op_writes(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/alu_rf.sv
// Register file: two combinational read ports, one synchronous write port
// and a registered debug read that returns the pre-write value.
module alu_rf #(
  parameter int NREG = 4,
  parameter int W    = 8,
  parameter int IW   = 2
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic [IW-1:0] sa,
  output logic [W-1:0]  a_data,
  input  logic [IW-1:0] sb,
  output logic [W-1:0]  b_data,
  input  logic          we,
  input  logic [IW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [IW-1:0] rd_sel,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [NREG];

  assign a_data = mem[sa];
  assign b_data = mem[sb];

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (we) mem[wa] <= wd;
      rd_data <= mem[rd_sel];
    end
  end

endmodule

// File: rtl/alu_issue.sv
// In-order issue stage for a fixed-latency external ALU: operand fetch,
// scoreboard hazard stall, tag pipe and register write-back.
module alu_issue
  import alu_pkg::*;
#(
  parameter int NREG = 4,
  parameter int W    = 8
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_op,
  input  logic [$clog2(NREG)-1:0] in_dst,
  input  logic [$clog2(NREG)-1:0] in_sa,
  input  logic [$clog2(NREG)-1:0] in_sb,
  input  logic [W-1:0]            in_imm,
  output logic [W-1:0]            A,
  output logic [W-1:0]            B,
  output logic [3:0]              CTR,
  input  logic [W-1:0]            alu_o,
  output logic                    wb_valid,
  output logic [$clog2(NREG)-1:0] wb_dst,
  output logic [W-1:0]            wb_data,
  input  logic [$clog2(NREG)-1:0] rd_sel,
  output logic [W-1:0]            rd_data
);

  localparam int IW = $clog2(NREG);

  typedef struct packed {
    tag_ctl_t      ctl;
    logic [IW-1:0] dst;
    logic [W-1:0]  imm;
  } tag_t;

  tag_t         pipe [LAT];
  tag_t         tag_in;
  logic         hazard;
  logic         accept;
  logic [W-1:0] rf_a;
  logic [W-1:0] rf_b;
  logic         wb_we;
  logic [W-1:0] wb_val;

  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both high. in_ready only drops while in_valid is high and a
  // source register has an outstanding write in the tag pipe.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (pipe[i].ctl.valid && pipe[i].ctl.wen &&
          (pipe[i].dst == in_sa || pipe[i].dst == in_sb))
        hazard = 1'b1;
    end
  end

  assign in_ready = !(in_valid && hazard);
  assign accept   = in_valid && in_ready;

  always_comb begin
    tag_in            = '0;
    tag_in.ctl.valid  = accept;
    tag_in.ctl.wen    = accept && op_writes(in_op);
    tag_in.ctl.is_ldi = (in_op == OP_LDI);
    tag_in.dst        = in_dst;
    tag_in.imm        = in_imm;
  end

  assign wb_we  = pipe[LAT-1].ctl.valid && pipe[LAT-1].ctl.wen;
  assign wb_val = pipe[LAT-1].ctl.is_ldi ? pipe[LAT-1].imm : alu_o;

  // Tag pipe never stalls; an empty slot carries valid=0.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      A        <= '0;
      B        <= '0;
      CTR      <= OP_NOP;
      wb_valid <= 1'b0;
      wb_dst   <= '0;
      wb_data  <= '0;
    end else begin
      if (accept) begin
        A <= rf_a;
        B <= rf_b;
      end
      CTR      <= (accept && is_alu_op(in_op)) ? in_op : OP_NOP;
      wb_valid <= wb_we;
      if (wb_we) begin
        wb_dst  <= pipe[LAT-1].dst;
        wb_data <= wb_val;
      end
    end
  end

  alu_rf #(.NREG(NREG), .W(W), .IW(IW)) u_rf (
    .ck      (ck),
    .rst_n   (rst_n),
    .sa      (in_sa),
    .a_data  (rf_a),
    .sb      (in_sb),
    .b_data  (rf_b),
    .we      (wb_we),
    .wa      (pipe[LAT-1].dst),
    .wd      (wb_val),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a behavioural 3-edge ALU, a register-file model with an
// outstanding-write queue, directed scenarios and a randomized phase.
module tb_alu_issue;

  logic       ck = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_dst, in_sa, in_sb;
  logic [7:0] in_imm;
  logic [7:0] A, B;
  logic [3:0] CTR;
  logic [7:0] alu_o = 8'h00;
  logic       wb_valid;
  logic [1:0] wb_dst;
  logic [7:0] wb_data;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;

  always #5 ck = ~ck;

  alu_issue #(.NREG(4), .W(8)) dut (
    .ck(ck), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dst(in_dst), .in_sa(in_sa), .in_sb(in_sb),
    .in_imm(in_imm), .A(A), .B(B), .CTR(CTR), .alu_o(alu_o),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      4'hB: return ~a;
      4'hC: return a >> 1;
      4'hD: return a << 1;
      4'hE: return {a[0], a[7:1]};
      4'hF: return {a[6:0], a[7]};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    return (op == 4'h0) || (op == 4'h1) || op[3];
  endfunction

  // External ALU: samples operands one edge after issue, result valid one edge later.
  logic [7:0] s_a = 8'h00, s_b = 8'h00;
  logic [3:0] s_c = 4'h3;
  always @(posedge ck) begin
    s_a   <= A;
    s_b   <= B;
    s_c   <= CTR;
    alu_o <= alu_ref(s_c, s_a, s_b);
  end

  typedef struct {
    int unsigned due;
    logic [1:0]  dst;
    logic [7:0]  data;
  } wb_t;

  wb_t         exp_q[$];
  logic [7:0]  m_rf [4];
  int unsigned n = 0;
  int          checks = 0;
  int          failures = 0;
  int          wb_seen = 0;
  logic        acc;
  int          st;
  int          wb0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
  endtask

  // One clock: check in_ready before the edge, then outputs just after it.
  task automatic step(output logic accepted);
    logic       hz;
    logic [7:0] res, opa, opb, rd_exp;
    logic [3:0] ctr_exp;
    @(negedge ck);
    hz = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].dst == in_sa || exp_q[i].dst == in_sb) hz = 1'b1;
    check_eq("in_ready", in_ready, !(in_valid && hz));
    accepted = in_valid && !hz;
    opa = m_rf[in_sa];
    opb = m_rf[in_sb];
    res = (in_op == 4'h2) ? in_imm : alu_ref(in_op, opa, opb);
    ctr_exp = (accepted && is_alu(in_op)) ? in_op : 4'h3;
    rd_exp = m_rf[rd_sel];
    @(posedge ck);
    n++;
    #1;
    check_eq("ctr", CTR, ctr_exp);
    if (accepted) begin
      check_eq("op_a", A, opa);
      check_eq("op_b", B, opb);
    end
    check_eq("rd_data", rd_data, rd_exp);
    if (wb_valid) wb_seen++;
    if (exp_q.size() > 0 && exp_q[0].due == n) begin
      check_eq("wb_valid", wb_valid, 1);
      check_eq("wb_dst", wb_dst, exp_q[0].dst);
      check_eq("wb_data", wb_data, exp_q[0].data);
      m_rf[exp_q[0].dst] = exp_q[0].data;
      void'(exp_q.pop_front());
    end else begin
      check_eq("wb_idle", wb_valid, 0);
    end
    if (accepted && (is_alu(in_op) || in_op == 4'h2))
      exp_q.push_back('{due: n + 3, dst: in_dst, data: res});
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [7:0] imm, output int stalls);
    logic a;
    in_valid = 1'b1;
    in_op = op; in_dst = dst; in_sa = sa; in_sb = sb; in_imm = imm;
    stalls = 0;
    a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(a);
      if (a) break;
      stalls++;
    end
    check_eq("issue_accept", a, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic a;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (exp_q.size() == 0) break;
      step(a);
    end
  endtask

  task automatic read_reg(input logic [1:0] idx, input logic [7:0] exp, input string tag);
    logic a;
    drain();
    rd_sel = idx;
    step(a);
    check_eq(tag, rd_data, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1; in_op = 4'h0; in_dst = 2'd0; in_sa = 2'd0; in_sb = 2'd0;
    in_imm = 8'h00; rd_sel = 2'd0;
    model_clear();
    repeat (2) @(posedge ck);
    #1;
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_a", A, 0);
    check_eq("rst_b", B, 0);
    check_eq("rst_ctr", CTR, 4'h3);
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_wb_dst", wb_dst, 0);
    check_eq("rst_wb_data", wb_data, 0);
    check_eq("rst_rd_data", rd_data, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Basic load/add with exact write-back latency.
    issue(4'h2, 2'd0, 2'd3, 2'd3, 8'h05, st);
    issue(4'h2, 2'd1, 2'd3, 2'd3, 8'h03, st);
    issue(4'h0, 2'd2, 2'd0, 2'd1, 8'h00, st);
    for (int k = 0; k < 3; k++) step(acc);
    check_eq("add_wb_valid", wb_valid, 1);
    check_eq("add_wb_dst", wb_dst, 2);
    check_eq("add_wb_data", wb_data, 8'h08);

    issue(4'h1, 2'd3, 2'd1, 2'd0, 8'h00, st);
    read_reg(2'd3, 8'hFE, "sub_r3");

    // NOP holds a slot but never writes.
    issue(4'h5, 2'd1, 2'd3, 2'd3, 8'h77, st);
    for (int k = 0; k < 4; k++) begin
      step(acc);
      check_eq("nop_no_wb", wb_valid, 0);
    end
    read_reg(2'd1, 8'h03, "nop_r1");

    // Dependent instruction stalls three cycles.
    issue(4'h0, 2'd2, 2'd0, 2'd1, 8'h00, st);
    issue(4'hA, 2'd3, 2'd2, 2'd0, 8'h00, st);
    check_eq("raw_stalls", st, 3);
    read_reg(2'd3, 8'h0D, "xor_r3");

    issue(4'h2, 2'd0, 2'd3, 2'd3, 8'h81, st);
    issue(4'hF, 2'd1, 2'd0, 2'd0, 8'h00, st);
    issue(4'hC, 2'd2, 2'd0, 2'd0, 8'h00, st);
    read_reg(2'd1, 8'h03, "rol_r1");
    read_reg(2'd2, 8'h40, "shr_r2");

    // Back-to-back independent loads.
    drain();
    wb0 = wb_seen;
    for (int k = 0; k < 10; k++) begin
      issue(4'h2, 2'(k % 4), 2'(k % 4), 2'(k % 4), 8'($urandom_range(0, 255)), st);
      check_eq("ldi_stall", st, 0);
    end
    drain();
    check_eq("ldi_wb_count", wb_seen - wb0, 10);

    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_op    = 4'($urandom_range(0, 15));
      in_dst   = 2'($urandom_range(0, 3));
      in_sa    = 2'($urandom_range(0, 3));
      in_sb    = 2'($urandom_range(0, 3));
      in_imm   = 8'($urandom_range(0, 255));
      rd_sel   = 2'($urandom_range(0, 3));
      step(acc);
    end
    drain();

    // Reset right after an accepted ADD discards it.
    issue(4'h0, 2'd2, 2'd0, 2'd1, 8'h00, st);
    rst_n = 1'b0;
    in_valid = 1'b1; in_sa = 2'd2; in_sb = 2'd2;
    #2;
    check_eq("ready_in_reset", in_ready, 1);
    @(posedge ck);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    model_clear();
    for (int k = 0; k < 5; k++) begin
      step(acc);
      check_eq("post_rst_no_wb", wb_valid, 0);
    end
    for (int r = 0; r < 4; r++) read_reg(2'(r), 8'h00, "post_rst_rf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter NREG, default 4: register-file depth, power of two, 2..16.
REQ-002 Parameter W, default 8: data width; must equal the ALU operand width.
REQ-003 ck  input  1  sole clock; all state updates on posedge ck.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  instruction accepted this edge when in_valid && in_ready.
REQ-007 in_op  input  4  ALU code (0000,0001,1000-1111), LDI=0010, or any other value as NOP.
REQ-008 in_dst, in_sa, in_sb  input  log2(NREG) each  destination and source register indices.
REQ-009 in_imm  input  W  immediate for LDI.
REQ-010 A, B  output  W  registered operands to the ALU.
REQ-011 CTR  output  4  registered ALU control.
REQ-012 alu_o  input  W  ALU result O.
REQ-013 wb_valid, wb_dst, wb_data  output  1/log2(NREG)/W  registered write-back report.
REQ-014 rd_sel  input  log2(NREG); rd_data  output  W: registered debug read of the register file.

Function
REQ-015 Accept: on an edge with in_valid && in_ready, A<=RF[in_sa], B<=RF[in_sb], CTR<=in_op (0011 for LDI and NOP); otherwise CTR<=0011, A/B hold.
REQ-016 ALU timing: ALU samples A/B/CTR at edge t+1, presents O after t+2; block samples alu_o at edge t+3 (fixed latency LAT=3).
REQ-017 In-flight tag pipe, 3 stages: {valid, wen, dst, is_ldi, imm}; advances every cycle, never stalls.
REQ-018 wen=1 for ALU codes and LDI, 0 for NOP; NOP occupies a slot but never writes.
REQ-019 Write-back at edge t+3: RF[dst] <= is_ldi ? imm : alu_o; same edge wb_valid<=1, wb_dst, wb_data<=written value; else wb_valid<=0.
REQ-020 Hazard: in_ready=0 when in_valid and in_sa or in_sb equals dst of any tag stage with valid&&wen; in_ready combinational, otherwise 1.
REQ-021 Write-back on same edge as a read of the same register: the hazard rule forbids issue, so no bypass is built.
REQ-022 WAW: in-order single write port; back-to-back writes to one register retire in issue order, later wins.
REQ-023 Throughput: one instruction per cycle with no dependency; dependent instruction issues 3 cycles after its producer.
REQ-024 rd_data <= RF[rd_sel] each edge, value before the same-edge write.
REQ-025 All arithmetic W bits modulo 2^W; block never interprets results.

Reset
REQ-026 rst_n low: RF all 0, tag valid all 0, A=B=0, CTR=0011, wb_valid=0, wb_dst=0, wb_data=0, rd_data=0.
REQ-027 Reset mid-operation discards all in-flight instructions; no write-back follows rst_n release.
REQ-028 in_ready is 1 during and after reset (no valid tags).

Structure
REQ-029 Package alu_pkg: opcode constants (ADD,SUB,LAND,LOR,XOR,NOT,SHR,SHL,ROR,ROL,LDI,NOP=0011), LAT=3, tag-record typedef.
REQ-030 One sub-module alu_rf: NREG x W, two combinational read ports, one synchronous write port, one registered debug read port.

Verification
REQ-031 Reset, LDI r0=0x05, LDI r1=0x03, ADD r2=r0+r1 -> wb_valid with wb_dst=2, wb_data=0x08 exactly 3 edges after ADD accept.
REQ-032 SUB r3=r1-r0 (3-5) -> wb_data=0xFE; ROL on 0x81 -> 0x03; SHR on 0x81 -> 0x40.
REQ-033 ADD r2 then immediately XOR r3=r2^r0 -> in_ready low 3 cycles, XOR uses 0x08, result 0x0D.
REQ-034 10 independent LDIs back-to-back -> in_ready never drops, 10 consecutive wb_valid pulses in order.
REQ-035 NOP (in_op=0101) to r1 -> no wb_valid, rd_sel=1 still reads 0x03.
REQ-036 rst_n low one cycle after an ADD accept -> no wb_valid after release, all rd_data reads 0.
